// File: rtl/handshake_fifo_break_dv_if.sv
// Handshake bundle for the pipeline-break FIFO: upstream (ins) and downstream (outs)
// channels plus occupancy. The FIFO uses the slave view; its environment uses master.
interface handshake_fifo_break_dv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic [LW-1:0]         level;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid, level
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid, level
  );
endinterface

// File: rtl/handshake_fifo_break_dv.sv
// Registered FIFO that breaks both valid and ready timing paths between producer and
// consumer; handshake flags come straight from flops, storage is per-entry registers.
module handshake_fifo_break_dv_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Payload registers carry no reset; only the pointers/flags define validity.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module handshake_fifo_break_dv #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  handshake_fifo_break_dv_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0]                     wr_ptr, rd_ptr;
  logic [LW-1:0]                     level_q, level_nxt;
  logic                              ready_q, valid_q;
  logic                              push, pop;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem;

  assign push = bus.ins_valid & ready_q;
  assign pop  = valid_q & bus.outs_ready;

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
  end

  // ready/valid are registered copies of the next-level compare, so neither output
  // has a combinational path from the opposite side of the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level_q <= level_nxt;
      ready_q <= (level_nxt != LW'(DEPTH));
      valid_q <= (level_nxt != '0);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    handshake_fifo_break_dv_entry #(.W(DATA_WIDTH)) u_entry (
      .clk (clk),
      .we  (push && (wr_ptr == PW'(i))),
      .d   (bus.ins),
      .q   (mem[i])
    );
  end

  assign bus.outs       = mem[rd_ptr];
  assign bus.outs_valid = valid_q;
  assign bus.ins_ready  = ready_q;
  assign bus.level      = level_q;
endmodule

// File: tb/tb_handshake_fifo_break_dv.sv
// Directed plus randomized check of handshake_fifo_break_dv against a queue model.
module tb_handshake_fifo_break_dv;
  localparam int DW    = 12;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] q[$];
  bit   last_push;

  always #5 clk = ~clk;

  handshake_fifo_break_dv_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  handshake_fifo_break_dv #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model at the negedge, then apply the handshake
  // rules at the rising edge to advance the model.
  task automatic cycle();
    bit push, pop;
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("ins_ready", 32'(bus.ins_ready), 32'(q.size() != DEPTH));
    chk("outs_valid", 32'(bus.outs_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("outs", 32'(bus.outs), 32'(q[0]));
    push = bus.ins_valid && (q.size() != DEPTH);
    pop  = bus.outs_ready && (q.size() != 0);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(bus.ins);
    last_push = push;
    @(negedge clk);
  endtask

  initial begin
    bus.ins        = '0;
    bus.ins_valid  = 1'b0;
    bus.outs_ready = 1'b0;
    last_push      = 1'b0;

    // Reset state held without release
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_ins_ready", 32'(bus.ins_ready), 1);
    chk("rst_outs_valid", 32'(bus.outs_valid), 0);
    rst = 1'b1;

    // Single token, pushed on the first edge after release
    bus.ins = 12'hF32; bus.ins_valid = 1'b1;
    cycle();
    bus.ins_valid = 1'b0;
    chk("t1_outs", 32'(bus.outs), 32'h0F32);
    chk("t1_level", 32'(bus.level), 1);
    cycle();
    bus.outs_ready = 1'b1;
    cycle();
    chk("t1_empty_valid", 32'(bus.outs_valid), 0);
    chk("t1_empty_level", 32'(bus.level), 0);
    cycle();  // outs_ready high on empty: no effect
    bus.outs_ready = 1'b0;

    // Fill to DEPTH, fifth offer held off
    for (int i = 1; i <= 4; i++) begin
      bus.ins = DW'(i); bus.ins_valid = 1'b1;
      cycle();
    end
    bus.ins = DW'(5);
    cycle(); cycle();
    chk("full_level", 32'(bus.level), 4);
    chk("full_ready", 32'(bus.ins_ready), 0);
    chk("full_head", 32'(bus.outs), 1);
    // Pop while full with ins_valid high: no push on that edge
    bus.outs_ready = 1'b1;
    cycle();
    chk("fullpop_level", 32'(bus.level), 3);
    chk("fullpop_ready", 32'(bus.ins_ready), 1);
    bus.outs_ready = 1'b0;
    cycle();
    chk("refill_level", 32'(bus.level), 4);
    bus.ins_valid = 1'b0; bus.outs_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("drain_order", 32'(bus.outs), 32'(i));
      cycle();
    end
    chk("drain_empty", 32'(bus.level), 0);
    bus.outs_ready = 1'b0;

    // Steady state at level 2 with pointer wrap
    for (int i = 0; i < 2; i++) begin
      bus.ins = DW'(12'h100 + i); bus.ins_valid = 1'b1;
      cycle();
    end
    bus.outs_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      bus.ins = DW'(12'h100 + i);
      cycle();
      chk("stream_level", 32'(bus.level), 2);
    end
    chk("stream_head", 32'(bus.outs), 32'h10A);
    bus.ins_valid = 1'b0;
    cycle(); cycle(); cycle();
    bus.outs_ready = 1'b0;

    // Async reset mid-stream at level 3
    for (int i = 0; i < 3; i++) begin
      bus.ins = DW'(12'h300 + i); bus.ins_valid = 1'b1;
      cycle();
    end
    bus.ins_valid = 1'b0;
    chk("pre_rst_level", 32'(bus.level), 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.outs_valid), 0);
    chk("mid_rst_ready", 32'(bus.ins_ready), 1);
    chk("mid_rst_level", 32'(bus.level), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    bus.ins = 12'h0A5; bus.ins_valid = 1'b1;
    cycle();
    bus.ins_valid = 1'b0;
    chk("post_rst_outs", 32'(bus.outs), 32'h0A5);
    chk("post_rst_level", 32'(bus.level), 1);
    bus.outs_ready = 1'b1;
    cycle(); cycle();
    chk("post_rst_empty", 32'(bus.outs_valid), 0);

    // Random stalls on both sides; upstream holds an offer until it is taken
    bus.ins_valid = 1'b0; last_push = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (!bus.ins_valid || last_push) begin
        bus.ins_valid = ($urandom_range(0, 3) != 0);
        bus.ins       = DW'($urandom);
      end
      bus.outs_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.ins_valid = 1'b0; bus.outs_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    chk("final_empty", 32'(bus.level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
